beta_lsu_ctrl: RTL and testbench
================================

# beta_lsu_ctrl

Parametrised load/store controller between the execute stage and the data-memory port. It replaces the single-transaction read/write memory FSMs with one valid/ready request channel and one response channel. Loads may be pipelined, with up to MAX_OUTSTANDING in flight. The block handles byte-lane steering, sign/zero extension and misalignment trapping, and sits between EXE (request side) and the data bus (memory side).

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. NB = XLEN/8 byte lanes, OFFW = log2(NB).
- ADDR_W, 32, address width.
- MAX_OUTSTANDING, 2, depth of the pending-load queue; power of two, at least 1.

Ports:
- clk_i, in, 1: clock. Single clock domain.
- rst_i, in, 1: reset, asynchronous, active-high.
- req_valid_i / req_ready_o, in / out, 1 / 1: EXE request handshake.
- req_op_i, in, 1: 0 = load, 1 = store (MEM_LOAD_OP / MEM_STORE_OP).
- req_size_i, in, 2: 00 word, 01 half, 10 byte, 11 illegal.
- req_unsigned_i, in, 1: zero-extend load result when 1.
- req_addr_i / req_wdata_i, in, ADDR_W / XLEN: byte address and store data (right-aligned).
- dmem_req_valid_o / dmem_req_ready_i, out / in, 1 / 1: memory request handshake.
- dmem_we_o, out, 1: 1 = store.
- dmem_be_o, out, NB: byte enables.
- dmem_addr_o / dmem_wdata_o, out, ADDR_W / XLEN: NB-aligned address and lane-steered data.
- dmem_rsp_valid_i / dmem_rdata_i, in / in, 1 / XLEN: load response. No backpressure; responses arrive in order.
- rsp_valid_o / rsp_rdata_o, out / out, 1 / XLEN: extended load result to writeback.
- err_o / err_addr_o, out / out, 1 / ADDR_W: misalignment or illegal-size trap.
- busy_o, out, 1: a request is held or a load is outstanding.

## Operation
- Issue FSM states:
  - IDLE: no request held.
  - WRDY: request held, dmem_req_valid_o = 1.
- Transitions:
  - IDLE -> WRDY on an accepted aligned request.
  - WRDY -> IDLE on dmem_req_ready_i, unless a new request is accepted in the same cycle, in which case the FSM stays in WRDY.
- Occupancy: occ = cnt + (WRDY && held op is load), where cnt counts issued loads not yet answered.
- Acceptance: req_ready_o = (state == IDLE || dmem_req_ready_i) && (occ < MAX_OUTSTANDING). Stores are also gated by this occupancy condition.
- Misalignment:
  - half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - The request is accepted and no memory request is issued.
  - err_o pulses for 1 cycle, the cycle after acceptance, with err_addr_o = req_addr_i.
- Lane steering, with off = addr[OFFW-1:0]:
  - byte: be = 1 << off, wdata = wdata[7:0] << 8·off.
  - half: be = 2'b11 << off, wdata = wdata[15:0] << 8·off.
  - word: be = 4'hF << off, wdata = wdata[31:0] << 8·off.
  - dmem_addr_o = addr with its low OFFW bits cleared.
- Stores are posted: nothing is queued and no response is expected.
- Loads: at the memory handshake {size, unsigned, off} is pushed into the pending FIFO and cnt is incremented.
- Response: dmem_rsp_valid_i pops the FIFO head. The result is rdata >> 8·off, truncated to size, then sign- or zero-extended to XLEN.
- A dmem_rsp_valid_i with cnt == 0 is ignored and has no side effects.
- Push and pop in the same cycle leave cnt unchanged. The FIFO pointers wrap modulo MAX_OUTSTANDING.
- busy_o = (state == WRDY) || (cnt != 0).

## Timing
- Reset values: state IDLE, cnt 0, FIFO pointers 0. All outputs 0 except req_ready_o = 1, which is combinational from the reset-state registers.
- Reset asserted mid-operation drops held and outstanding requests. Responses arriving after reset are ignored because cnt == 0.
- Request path: request accepted in cycle N gives dmem_req_valid_o = 1 in cycle N+1, with dmem_* registered.
- While dmem_req_valid_o is high and dmem_req_ready_i is low, dmem_* are held stable.
- Back-to-back throughput with dmem_req_ready_i tied high: one request per cycle.
- Response path: dmem_rsp_valid_i in cycle M gives rsp_valid_o for one cycle in M+1, registered.
- With MAX_OUTSTANDING loads in flight, req_ready_o = 0. A response pop in the same cycle does not reopen req_ready_o until the next cycle, because cnt is registered.
- err_o never coincides with dmem_req_valid_o for the same request.

## Test plan
- LB at 0x1003 with rdata 0x80FF_0000 -> dmem_addr_o 0x1000, be 0b1000. Result 0xFFFF_FF80; with the LBU variant, 0x0000_0080.
- SH of 0x1234 at 0x2002 -> be 0b1100, dmem_wdata_o 0x1234_0000, dmem_we_o 1. No rsp_valid_o.
- LW at 0x3001 -> err_o 1 for exactly one cycle with err_addr_o 0x3001. No dmem_req_valid_o.
- MAX_OUTSTANDING = 2: three LWs with dmem_req_ready_i high and responses delayed 5 cycles -> third request stalled (req_ready_o 0) until cycle after the first response. Results are returned in order.
- dmem_req_ready_i held low 4 cycles -> dmem_addr_o, dmem_be_o, dmem_wdata_o stable across all 4 cycles. Handshake completes on cycle 5.
- rst_i asserted with two loads outstanding, then a stray dmem_rsp_valid_i -> no rsp_valid_o, busy_o 0, req_ready_o 1.

Source files
------------

// File: rtl/beta_lsu_ctrl.sv
// Load/store controller between EXE and the data-memory port: one request channel,
// byte-lane steering, misalignment trapping and a pending-load queue for in-order responses.
module beta_lsu_ctrl #(
    parameter int XLEN            = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_op_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic              dmem_we_o,
    output logic [XLEN/8-1:0] dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_rsp_valid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic              busy_o
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNTW:0]   OCC_MAX  = (CNTW + 1)'(MAX_OUTSTANDING);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(MAX_OUTSTANDING - 1);

    typedef enum logic {S_IDLE, S_WRDY} state_t;
    state_t r_state, w_state_nxt;

    logic              r_we;
    logic [NB-1:0]     r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [OFFW-1:0]   r_off;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic [CNTW-1:0]   r_cnt;
    logic [PTRW-1:0]   r_wptr, r_rptr;
    logic [1:0]        r_q_size [MAX_OUTSTANDING];
    logic              r_q_uns  [MAX_OUTSTANDING];
    logic [OFFW-1:0]   r_q_off  [MAX_OUTSTANDING];
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;

    logic            w_misalign, w_accept, w_issue, w_held_load, w_dmem_hs;
    logic            w_push, w_pop;
    logic [CNTW:0]   w_occ;
    logic [OFFW-1:0] w_off;
    logic [NB-1:0]   w_be_base, w_be;
    logic [XLEN-1:0] w_wmask, w_wdata;
    logic [1:0]      w_h_size;
    logic            w_h_uns;
    logic [OFFW-1:0] w_h_off;
    logic [XLEN-1:0] w_shift, w_ext;
    logic            w_sign, w_fill;
    int              w_wid;

    assign w_off       = req_addr_i[OFFW-1:0];
    assign w_held_load = (r_state == S_WRDY) && !r_we;
    assign w_occ       = {1'b0, r_cnt} + {{CNTW{1'b0}}, w_held_load};
    assign w_dmem_hs   = (r_state == S_WRDY) && dmem_req_ready_i;

    always_comb begin
        w_misalign = 1'b0;
        case (req_size_i)
            2'b00:   w_misalign = |req_addr_i[1:0];
            2'b01:   w_misalign = req_addr_i[0];
            2'b10:   w_misalign = 1'b0;
            default: w_misalign = 1'b1;
        endcase
    end

    // Issue FSM: a new request may be latched in the same cycle the held one handshakes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        req_ready_o      = ((r_state == S_IDLE) || dmem_req_ready_i) && (w_occ < OCC_MAX);
        w_accept         = req_valid_i && req_ready_o;
        w_issue          = w_accept && !w_misalign;
        dmem_req_valid_o = (r_state == S_WRDY);
        case (r_state)
            S_IDLE: if (w_issue) w_state_nxt = S_WRDY;
            S_WRDY: if (dmem_req_ready_i && !w_issue) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_be_base = '0;
        w_wmask   = '0;
        case (req_size_i)
            2'b10:   begin w_be_base = NB'(1);    w_wmask = XLEN'(32'h0000_00FF); end
            2'b01:   begin w_be_base = NB'(3);    w_wmask = XLEN'(32'h0000_FFFF); end
            2'b00:   begin w_be_base = NB'(4'hF); w_wmask = XLEN'(32'hFFFF_FFFF); end
            default: begin w_be_base = '0;        w_wmask = '0;                   end
        endcase
        w_be    = w_be_base << w_off;
        w_wdata = (req_wdata_i & w_wmask) << {w_off, 3'b000};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_uns      <= 1'b0;
            r_off      <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_err <= w_accept && w_misalign;
            if (w_accept && w_misalign) r_err_addr <= req_addr_i;
            if (w_issue) begin
                r_we    <= req_op_i;
                r_be    <= w_be;
                r_addr  <= {req_addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                r_wdata <= w_wdata;
                r_size  <= req_size_i;
                r_uns   <= req_unsigned_i;
                r_off   <= w_off;
            end
        end
    end

    // Pending-load queue: one entry per load handed to memory, popped by each response.
    assign w_push = w_dmem_hs && !r_we;
    assign w_pop  = dmem_rsp_valid_i && (r_cnt != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_q_size[i] <= '0;
                r_q_uns[i]  <= 1'b0;
                r_q_off[i]  <= '0;
            end
        end else begin
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
            if (w_push) begin
                r_q_size[r_wptr] <= r_size;
                r_q_uns[r_wptr]  <= r_uns;
                r_q_off[r_wptr]  <= r_off;
                r_wptr           <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
        end
    end

    assign w_h_size = r_q_size[r_rptr];
    assign w_h_uns  = r_q_uns[r_rptr];
    assign w_h_off  = r_q_off[r_rptr];

    always_comb begin
        w_shift = dmem_rdata_i >> {w_h_off, 3'b000};
        w_wid   = 32;
        w_sign  = w_shift[31];
        case (w_h_size)
            2'b10:   begin w_wid = 8;  w_sign = w_shift[7];  end
            2'b01:   begin w_wid = 16; w_sign = w_shift[15]; end
            default: begin w_wid = 32; w_sign = w_shift[31]; end
        endcase
        w_fill = w_sign && !w_h_uns;
        w_ext  = '0;
        for (int i = 0; i < XLEN; i++) w_ext[i] = (i < w_wid) ? w_shift[i] : w_fill;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) r_rsp_rdata <= w_ext;
        end
    end

    assign dmem_we_o    = r_we;
    assign dmem_be_o    = r_be;
    assign dmem_addr_o  = r_addr;
    assign dmem_wdata_o = r_wdata;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign err_o        = r_err;
    assign err_addr_o   = r_err_addr;
    assign busy_o       = (r_state == S_WRDY) || (r_cnt != '0);
endmodule

// File: tb/tb_beta_lsu_ctrl.sv
// Scoreboard bench for beta_lsu_ctrl: a reference model queues expected memory requests,
// traps and load results; independent monitors pop and compare whenever the DUT presents them.
module tb_beta_lsu_ctrl;
    localparam int XLEN = 32;
    localparam int ADDR_W = 32;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_valid_i = 1'b0, req_op_i = 1'b0, req_unsigned_i = 1'b0;
    logic [1:0]        req_size_i = 2'b00;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic [XLEN-1:0]   req_wdata_i = '0;
    logic              req_ready_o;
    logic              dmem_req_valid_o, dmem_req_ready_i, dmem_we_o;
    logic [3:0]        dmem_be_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [XLEN-1:0]   dmem_wdata_o;
    logic              dmem_rsp_valid_i;
    logic [XLEN-1:0]   dmem_rdata_i;
    logic              rsp_valid_o, err_o, busy_o;
    logic [XLEN-1:0]   rsp_rdata_o;
    logic [ADDR_W-1:0] err_addr_o;

    beta_lsu_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rsp_valid_i(dmem_rsp_valid_i),
        .dmem_rdata_i(dmem_rdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .err_o(err_o), .err_addr_o(err_addr_o), .busy_o(busy_o)
    );

    typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} mreq_t;
    typedef struct {int size; bit uns; int off;} ld_t;

    mreq_t       exp_req_q[$];
    ld_t         ld_q[$];
    logic [31:0] exp_rsp_q[$];
    logic [31:0] exp_err_q[$];
    int          due_q[$];
    int          rsp_cycs[$];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit rdy_force = 1'b0;
    int dly_min = 1, dly_max = 3;
    int last_due = 0;
    bit use_forced = 1'b0;
    bit stray_req = 1'b0;
    logic [31:0] forced_rdata = '0;
    logic [31:0] last_rsp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] model_load(ld_t l, logic [31:0] rd);
        logic [63:0] v;
        logic [63:0] m;
        int w;
        w = (l.size == 2) ? 8 : (l.size == 1) ? 16 : 32;
        m = (64'd1 << w) - 64'd1;
        v = ({32'b0, rd} >> (8 * l.off)) & m;
        if (!l.uns && v[w-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // Memory side: ready pattern, in-order delayed responses, expected load results.
    initial begin
        ld_t l;
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0;
        dmem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: dmem_req_ready_i = 1'b1;
                1: dmem_req_ready_i = ($urandom_range(0, 99) < 70);
                default: dmem_req_ready_i = rdy_force;
            endcase
            dmem_rsp_valid_i = 1'b0;
            dmem_rdata_i = $urandom;
            if (stray_req) begin
                dmem_rsp_valid_i = 1'b1;
            end else if (due_q.size() > 0 && cyc >= due_q[0]) begin
                void'(due_q.pop_front());
                dmem_rsp_valid_i = 1'b1;
                if (use_forced) dmem_rdata_i = forced_rdata;
                rsp_cycs.push_back(cyc);
                if (ld_q.size() > 0) begin
                    l = ld_q.pop_front();
                    exp_rsp_q.push_back(model_load(l, dmem_rdata_i));
                end
            end
        end
    end

    // Monitors: compare every memory handshake, load result and trap against the queues.
    always @(negedge clk) begin
        mreq_t e;
        int d;
        if (!rst) begin
            if (dmem_req_valid_o && dmem_req_ready_i) begin
                if (exp_req_q.size() == 0) check("dmem_unexpected", dmem_req_valid_o, 0);
                else begin
                    e = exp_req_q.pop_front();
                    check("dmem_addr", dmem_addr_o, e.addr);
                    check("dmem_be", dmem_be_o, e.be);
                    check("dmem_we", dmem_we_o, e.we);
                    if (e.we) check("dmem_wdata", dmem_wdata_o, e.wdata);
                end
                if (!dmem_we_o) begin
                    d = cyc + $urandom_range(dly_min, dly_max);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    due_q.push_back(d);
                end
            end
            if (rsp_valid_o) begin
                last_rsp = rsp_rdata_o;
                if (exp_rsp_q.size() == 0) check("rsp_unexpected", rsp_valid_o, 0);
                else check("rsp_rdata", rsp_rdata_o, exp_rsp_q.pop_front());
            end
            if (err_o) begin
                if (exp_err_q.size() == 0) check("err_unexpected", err_o, 0);
                else check("err_addr", err_addr_o, exp_err_q.pop_front());
            end
        end
    end

    task automatic issue(input bit op, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int acc_cyc, output int waits);
        bit acc;
        bit mis;
        int off, bytes;
        mreq_t e;
        ld_t l;
        req_op_i = op; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wd; req_valid_i = 1'b1;
        acc = 1'b0; waits = 0;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (req_ready_o) acc = 1'b1;
            else waits++;
        end
        acc_cyc = cyc;
        if (!acc) check("accept_timeout", acc, 1);
        else begin
            off = int'(addr[1:0]);
            mis = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b00 && off != 0);
            if (mis) exp_err_q.push_back(addr);
            else begin
                bytes = (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
                e.addr = addr & ~32'h3;
                e.be = 4'(((1 << bytes) - 1) << off);
                e.wdata = 32'((({32'b0, wd}) & ((64'd1 << (8 * bytes)) - 64'd1)) << (8 * off));
                e.we = op;
                exp_req_q.push_back(e);
                if (!op) begin
                    l.size = int'(size); l.uns = uns; l.off = off;
                    ld_q.push_back(l);
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (!busy_o && ld_q.size() == 0 && exp_rsp_q.size() == 0 &&
                exp_req_q.size() == 0 && exp_err_q.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", done, 1);
        idle(2);
    endtask

    initial begin
        int a, w, a3, w3;
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, w, a3, w3;
        logic [31:0] s_addr, s_wd;
        logic [3:0]  s_be;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_dmem_valid", dmem_req_valid_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_dmem_addr", dmem_addr_o, 0);
        rst = 1'b0;
        idle(1);

        // LB / LBU at 0x1003 with rdata 0x80FF_0000
        use_forced = 1'b1; forced_rdata = 32'h80FF_0000;
        issue(0, 2'b10, 0, 32'h1003, 32'h0, a, w);
        @(negedge clk);
        check("lb_valid_n1", dmem_req_valid_o, 1);
        check("lb_addr", dmem_addr_o, 32'h1000);
        check("lb_be", dmem_be_o, 4'b1000);
        drain();
        check("lb_result", last_rsp, 32'hFFFF_FF80);
        issue(0, 2'b10, 1, 32'h1003, 32'h0, a, w);
        drain();
        check("lbu_result", last_rsp, 32'h0000_0080);
        use_forced = 1'b0;

        // SH of 0x1234 at 0x2002
        issue(1, 2'b01, 0, 32'h2002, 32'h0000_1234, a, w);
        @(negedge clk);
        check("sh_we", dmem_we_o, 1);
        check("sh_be", dmem_be_o, 4'b1100);
        check("sh_wdata", dmem_wdata_o, 32'h1234_0000);
        drain();

        // misaligned LW at 0x3001
        issue(0, 2'b00, 0, 32'h3001, 32'h0, a, w);
        @(negedge clk);
        check("mis_err", err_o, 1);
        check("mis_err_addr", err_addr_o, 32'h3001);
        check("mis_no_dmem", dmem_req_valid_o, 0);
        @(negedge clk);
        check("mis_err_pulse", err_o, 0);
        drain();

        // memory stalls for 4 cycles: held request must not move
        rdy_mode = 2; rdy_force = 1'b0;
        issue(1, 2'b10, 0, 32'h4001, 32'h0000_00AB, a, w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_valid", dmem_req_valid_o, 1);
            check("stall_addr", dmem_addr_o, 32'h4000);
            check("stall_be", dmem_be_o, 4'b0010);
            check("stall_wdata", dmem_wdata_o, 32'h0000_AB00);
        end
        rdy_force = 1'b1;
        @(negedge clk);
        check("stall_hs_cycle5", dmem_req_valid_o && dmem_req_ready_i, 1);
        @(negedge clk);
        check("stall_released", dmem_req_valid_o, 0);
        rdy_mode = 0;
        drain();

        // three LWs against a 2-deep queue with 5-cycle responses
        dly_min = 5; dly_max = 5;
        rsp_cycs.delete();
        issue(0, 2'b00, 0, 32'h100, 32'h0, a, w);
        issue(0, 2'b00, 0, 32'h104, 32'h0, a, w);
        issue(0, 2'b00, 0, 32'h108, 32'h0, a3, w3);
        check("max_out_stalled", w3 > 0, 1);
        drain();
        check("max_out_rsp_count", rsp_cycs.size(), 3);
        if (rsp_cycs.size() > 0) check("max_out_reopen_cycle", a3, rsp_cycs[0] + 1);

        // reset with two loads outstanding, then a stray response
        dly_min = 20; dly_max = 20;
        issue(0, 2'b00, 0, 32'h200, 32'h0, a, w);
        issue(0, 2'b01, 0, 32'h206, 32'h0, a, w);
        idle(3);
        @(negedge clk);
        check("pre_rst_busy", busy_o, 1);
        rst = 1'b1;
        ld_q.delete(); exp_rsp_q.delete(); due_q.delete(); exp_req_q.delete();
        last_due = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        stray_req = 1'b1;
        idle(1);
        stray_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_rsp", rsp_valid_o, 0);
            check("post_rst_busy", busy_o, 0);
            check("post_rst_ready", req_ready_o, 1);
        end
        idle(1);

        // randomized traffic with random memory ready and response delays
        dly_min = 1; dly_max = 6; rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  $urandom & 32'h0000_0FFF, $urandom, a, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 0;
        drain();
        check("end_req_q_empty", exp_req_q.size(), 0);
        check("end_rsp_q_empty", exp_rsp_q.size(), 0);
        check("end_err_q_empty", exp_err_q.size(), 0);
        check("end_busy", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
